sdram_work_fsm: RTL and testbench
=================================

// Module: sdram_work_fsm
// PURPOSE
//  Core SDRAM sequencer, upstream of the SDRAM data-path stage. Arbitrates between
//  write requests, read requests and periodic auto-refresh. Drives the 4-bit work_state
//  code and the 9-bit cnt_clk counter that the data path uses to steer DQ and capture data.
//  Also returns write/read acknowledge strobes to the system side.
// PARAMETERS
//  TRCD        2    ACTIVE-to-READ/WRITE delay, cycles (>=1)
//  CL          3    CAS latency, cycles (>=1)
//  BURST_LEN   8    words per burst (1..256)
//  TRP         2    precharge wait after read burst, cycles (>=1)
//  TDAL        3    write-recovery + precharge wait, cycles (>=1)
//  TRFC        7    auto-refresh wait, cycles (>=1)
//  REF_PERIOD  780  cycles between refresh requests (<=65535)
// PORTS
//  clk           in   1   system clock, 100 MHz
//  rst           in   1   synchronous reset, active high
//  init_done     in   1   SDRAM power-up init complete; FSM holds W_IDLE while low
//  sys_wr_req    in   1   write burst request, level, held until sdram_wr_ack seen
//  sys_rd_req    in   1   read burst request, level, held until sdram_rd_ack seen
//  work_state    out  4   state code to data path
//  cnt_clk       out  9   cycles spent in current state
//  sdram_wr_ack  out  1   high while the data path samples sys_data_in
//  sdram_rd_ack  out  1   high while sys_data_out holds a valid read word
//  sdram_busy    out  1   high when work_state!=W_IDLE or init_done low
// BEHAVIOUR
//  Codes: IDLE=0 ACTIVE=1 TRCD=2 READ=3 CL=4 RD=5 RWAIT=6 WRITE=7 WD=8 TDAL=9 AR=10 TRFC=11.
//  Reset: work_state=IDLE, cnt_clk=0, all acks 0, busy 1, refresh timer 0, pending cleared.
//  cnt_clk: cleared on every cycle where next state != current state; otherwise
//   increments; saturates at 511.
//  IDLE (init_done=1): priority refresh-pending > wr_req > rd_req. Refresh -> AR.
//   Otherwise -> ACTIVE, with the direction latched for the whole burst.
//   Neither request present -> stay in IDLE.
//  ACTIVE 1 cyc -> TRCD; TRCD exits at cnt_clk==TRCD-1 -> WRITE or READ per latched direction.
//  Write path:
//   WRITE 1 cyc (first word) -> WD for BURST_LEN-1 cyc -> TDAL for TDAL cyc -> IDLE.
//   If BURST_LEN==1, WRITE goes directly to TDAL.
//  Read path:
//   READ 1 cyc -> CL, exits at cnt_clk==CL-1 -> RD for BURST_LEN cyc -> RWAIT for TRP cyc -> IDLE.
//  Refresh path: AR 1 cyc -> TRFC for TRFC cyc -> IDLE.
//  sdram_wr_ack = combinational (work_state==WRITE | work_state==WD); BURST_LEN cycles per burst.
//  sdram_rd_ack = (work_state==RD) registered one cycle, aligned with the data-path capture
//   register; BURST_LEN cycles per burst.
//  Refresh timer: free-running counter wraps at REF_PERIOD-1. On wrap it sets pending.
//   Entering AR consumes one pending refresh. Wrap and consume in the same cycle: net
//   pending is unchanged.
//  A burst in progress is never pre-empted. Refresh is only taken from IDLE.
//  Requests deasserted mid-burst are ignored; the burst completes.
//  rst mid-burst: immediate return to reset values; DQ release is the data path's job.
// CONFIGURATION
//  SDRAM_REF_BACKLOG_EN defined:
//   Pending is a 2-bit counter saturating at 3.
//   Refreshes are issued back-to-back (TRFC -> IDLE -> AR) until the count reaches 0.
//  SDRAM_REF_BACKLOG_EN undefined:
//   Pending is a single flag; a wrap while the flag is set is lost.
// STRUCTURE
//  Shared package sdram_pkg: the 12 state-code constants, timing defaults, CNT_W=9.
//  Sub-module sdram_ref_timer: the refresh counter plus pending flag/backlog.
//   Ports: clk, rst, consume, ref_pending.
//  FSM, cnt_clk and acks stay in this module.
// TESTING (defaults, REF_PERIOD raised to 5000 except test 4)
//  1. rst high 3 cyc, init_done=0 then 1 -> state 0, busy 1 until init_done, then busy 0.
//  2. wr_req at IDLE -> states 1,2,2,7,8x7,9x3,0; wr_ack high exactly 8 cyc; cnt_clk 0..6 in WD.
//  3. rd_req -> 1,2,2,3,4x3,5x8,6x2,0; rd_ack 8 cyc, starting 1 cyc after first RD.
//  4. REF_PERIOD=20, wr_req and refresh pending together -> AR(10), TRFC(11) x7 first,
//     then write.
//  5. wr_req and rd_req together -> write burst, then read burst with no extra IDLE stall
//     beyond 1 cycle.
//  6. rst asserted mid-RD -> next cycle work_state=0, cnt_clk=0, rd_ack=0.
//     With SDRAM_REF_BACKLOG_EN and 3 missed periods -> 3 consecutive AR/TRFC sequences.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared state codes, timing defaults and counter width for the SDRAM work sequencer.
package sdram_pkg;

  localparam int CNT_W          = 9;
  localparam int TRCD_DEF       = 2;
  localparam int CL_DEF         = 3;
  localparam int BURST_LEN_DEF  = 8;
  localparam int TRP_DEF        = 2;
  localparam int TDAL_DEF       = 3;
  localparam int TRFC_DEF       = 7;
  localparam int REF_PERIOD_DEF = 780;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_RWAIT  = 4'd6,
    W_WRITE  = 4'd7,
    W_WD     = 4'd8,
    W_TDAL   = 4'd9,
    W_AR     = 4'd10,
    W_TRFC   = 4'd11
  } work_state_t;

  // cnt_clk value on the last cycle of a state that lasts n cycles
  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sdram_work_fsm_if.sv
// System/data-path side signals of the SDRAM work sequencer; slave = sequencer, master = user.
interface sdram_work_fsm_if;
  import sdram_pkg::*;

  logic             init_done;
  logic             sys_wr_req;
  logic             sys_rd_req;
  logic [3:0]       work_state;
  logic [CNT_W-1:0] cnt_clk;
  logic             sdram_wr_ack;
  logic             sdram_rd_ack;
  logic             sdram_busy;

  modport slave (
    input  init_done, sys_wr_req, sys_rd_req,
    output work_state, cnt_clk, sdram_wr_ack, sdram_rd_ack, sdram_busy
  );

  modport master (
    output init_done, sys_wr_req, sys_rd_req,
    input  work_state, cnt_clk, sdram_wr_ack, sdram_rd_ack, sdram_busy
  );

endinterface

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer with pending refresh tracking.
// SDRAM_REF_BACKLOG_EN: pending becomes a 2-bit backlog counter instead of a single flag.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic consume,
  output logic ref_pending
);

  localparam logic [15:0] C_WRAP = 16'(REF_PERIOD - 1);

  logic [15:0] r_tmr;
  logic        w_wrap;

  assign w_wrap = (r_tmr == C_WRAP);

  always_ff @(posedge clk) begin
    if (rst)         r_tmr <= '0;
    else if (w_wrap) r_tmr <= '0;
    else             r_tmr <= r_tmr + 16'd1;
  end

`ifdef SDRAM_REF_BACKLOG_EN
  logic [1:0] r_pend;

  // wrap and consume together cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 2'd0;
    end else if (w_wrap && !consume) begin
      if (r_pend != 2'd3) r_pend <= r_pend + 2'd1;
    end else if (!w_wrap && consume && (r_pend != 2'd0)) begin
      r_pend <= r_pend - 2'd1;
    end
  end

  assign ref_pending = |r_pend;
`else
  logic r_pend;

  always_ff @(posedge clk) begin
    if (rst)          r_pend <= 1'b0;
    else if (w_wrap)  r_pend <= 1'b1;
    else if (consume) r_pend <= 1'b0;
  end

  assign ref_pending = r_pend;
`endif

endmodule

// File: rtl/sdram_work_fsm.sv
// SDRAM work sequencer: arbitrates refresh/write/read bursts and drives work_state and cnt_clk.
// Refresh backlog behaviour is selected by SDRAM_REF_BACKLOG_EN inside sdram_ref_timer.
module sdram_work_fsm
  import sdram_pkg::*;
#(
  parameter int TRCD       = TRCD_DEF,
  parameter int CL         = CL_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int TRP        = TRP_DEF,
  parameter int TDAL       = TDAL_DEF,
  parameter int TRFC       = TRFC_DEF,
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sdram_work_fsm_if.slave  bus
);

  // IDLE wait/arbitrate | ACTIVE/TRCD row open | WRITE/WD write burst, TDAL recovery
  // READ/CL/RD read burst, RWAIT precharge | AR/TRFC auto-refresh
  localparam logic [CNT_W-1:0] C_TRCD_END = cnt_last(TRCD);
  localparam logic [CNT_W-1:0] C_CL_END   = cnt_last(CL);
  localparam logic [CNT_W-1:0] C_RD_END   = cnt_last(BURST_LEN);
  localparam logic [CNT_W-1:0] C_WD_END   = cnt_last(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] C_TRP_END  = cnt_last(TRP);
  localparam logic [CNT_W-1:0] C_TDAL_END = cnt_last(TDAL);
  localparam logic [CNT_W-1:0] C_TRFC_END = cnt_last(TRFC);

  work_state_t      r_state;
  work_state_t      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir_wr;
  logic             r_rd_ack;
  logic             w_ref_pending;
  logic             w_consume;
  logic             w_start;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk         (clk),
    .rst         (rst),
    .consume     (w_consume),
    .ref_pending (w_ref_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= W_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_consume = 1'b0;
    w_start   = 1'b0;
    case (r_state)
      W_IDLE: begin
        if (bus.init_done) begin
          if (w_ref_pending) begin
            w_next    = W_AR;
            w_consume = 1'b1;
          end else if (bus.sys_wr_req || bus.sys_rd_req) begin
            w_next  = W_ACTIVE;
            w_start = 1'b1;
          end
        end
      end
      W_ACTIVE: w_next = W_TRCD;
      W_TRCD: begin
        if (r_cnt == C_TRCD_END) begin
          if (r_dir_wr) w_next = W_WRITE;
          else          w_next = W_READ;
        end
      end
      W_WRITE: begin
        if (BURST_LEN == 1) w_next = W_TDAL;
        else                w_next = W_WD;
      end
      W_WD:    if (r_cnt == C_WD_END)   w_next = W_TDAL;
      W_TDAL:  if (r_cnt == C_TDAL_END) w_next = W_IDLE;
      W_READ:  w_next = W_CL;
      W_CL:    if (r_cnt == C_CL_END)   w_next = W_RD;
      W_RD:    if (r_cnt == C_RD_END)   w_next = W_RWAIT;
      W_RWAIT: if (r_cnt == C_TRP_END)  w_next = W_IDLE;
      W_AR:    w_next = W_TRFC;
      W_TRFC:  if (r_cnt == C_TRFC_END) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // write wins a simultaneous request; direction is frozen for the burst
  always_ff @(posedge clk) begin
    if (rst)          r_dir_wr <= 1'b0;
    else if (w_start) r_dir_wr <= bus.sys_wr_req;
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (r_cnt != '1)       r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_ack <= 1'b0;
    else     r_rd_ack <= (r_state == W_RD);
  end

  assign bus.work_state   = r_state;
  assign bus.cnt_clk      = r_cnt;
  assign bus.sdram_wr_ack = (r_state == W_WRITE) || (r_state == W_WD);
  assign bus.sdram_rd_ack = r_rd_ack;
  assign bus.sdram_busy   = (r_state != W_IDLE) || !bus.init_done;

endmodule

// File: tb/tb_sdram_work_fsm.sv
// Self-checking bench for sdram_work_fsm: table-driven arbitration scenarios plus refresh/reset sequences.
module tb_sdram_work_fsm;
  import sdram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m;
  logic rst_r;
  logic sel_r;

  sdram_work_fsm_if if_m ();
  sdram_work_fsm_if if_r ();

  sdram_work_fsm #(.REF_PERIOD(5000)) dut (
    .clk (clk),
    .rst (rst_m),
    .bus (if_m.slave)
  );

  sdram_work_fsm #(.REF_PERIOD(20)) dut_r (
    .clk (clk),
    .rst (rst_r),
    .bus (if_r.slave)
  );

  logic [3:0] mon_st;
  logic [8:0] mon_cnt;
  logic       mon_wa;
  logic       mon_ra;
  logic       mon_busy;

  always_comb begin
    if (sel_r) begin
      mon_st = if_r.work_state; mon_cnt = if_r.cnt_clk;
      mon_wa = if_r.sdram_wr_ack; mon_ra = if_r.sdram_rd_ack; mon_busy = if_r.sdram_busy;
    end else begin
      mon_st = if_m.work_state; mon_cnt = if_m.cnt_clk;
      mon_wa = if_m.sdram_wr_ack; mon_ra = if_m.sdram_rd_ack; mon_busy = if_m.sdram_busy;
    end
  end

  typedef struct {
    logic [3:0] st;
    int         cnt;
    logic       wr_ack;
    logic       rd_ack;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       init;
    logic       wr;
    logic       rd;
    logic [3:0] exp_st;
    logic       exp_busy;
    int         burst;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // rd_ack is expected one cycle after each RD cycle
  task automatic push(input logic [3:0] st, input int n, input logic wa, input int c0);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.st     = st;
      e.cnt    = (c0 < 0) ? -1 : c0 + i;
      e.wr_ack = wa;
      e.busy   = (st != 4'd0);
      e.rd_ack = (exp_q.size() > 0) && (exp_q[$].st == 4'd5);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_wr();
    push(4'd1, 1, 1'b0, 0); push(4'd2, 2, 1'b0, 0); push(4'd7, 1, 1'b1, 0);
    push(4'd8, 7, 1'b1, 0); push(4'd9, 3, 1'b0, 0); push(4'd0, 1, 1'b0, 0);
  endtask

  task automatic push_rd();
    push(4'd1, 1, 1'b0, 0); push(4'd2, 2, 1'b0, 0); push(4'd3, 1, 1'b0, 0);
    push(4'd4, 3, 1'b0, 0); push(4'd5, 8, 1'b0, 0); push(4'd6, 2, 1'b0, 0);
    push(4'd0, 1, 1'b0, 0);
  endtask

  task automatic push_ref();
    push(4'd10, 1, 1'b0, 0); push(4'd11, 7, 1'b0, 0); push(4'd0, 1, 1'b0, 0);
  endtask

  task automatic run_q(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d] state", tag, k), 16'(mon_st), 16'(e.st));
      if (e.cnt >= 0) chk($sformatf("%s[%0d] cnt_clk", tag, k), 16'(mon_cnt), 16'(e.cnt));
      chk($sformatf("%s[%0d] wr_ack", tag, k), 16'(mon_wa), 16'(e.wr_ack));
      chk($sformatf("%s[%0d] rd_ack", tag, k), 16'(mon_ra), 16'(e.rd_ack));
      chk($sformatf("%s[%0d] busy", tag, k), 16'(mon_busy), 16'(e.busy));
      if (mon_wa) begin
        if (sel_r) if_r.sys_wr_req = 1'b0; else if_m.sys_wr_req = 1'b0;
      end
      if (mon_ra) begin
        if (sel_r) if_r.sys_rd_req = 1'b0; else if_m.sys_rd_req = 1'b0;
      end
      k++;
    end
  endtask

  task automatic reset_m(input string tag);
    rst_m = 1'b1;
    if_m.init_done = 1'b0; if_m.sys_wr_req = 1'b0; if_m.sys_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " rst state"}, 16'(if_m.work_state), 16'd0);
    chk({tag, " rst cnt_clk"}, 16'(if_m.cnt_clk), 16'd0);
    chk({tag, " rst acks"}, 16'({if_m.sdram_wr_ack, if_m.sdram_rd_ack}), 16'd0);
    chk({tag, " rst busy"}, 16'(if_m.sdram_busy), 16'd1);
  endtask

  vec_t vt[6];

  initial begin
    sel_r = 1'b0;
    rst_r = 1'b1;
    if_r.init_done = 1'b0; if_r.sys_wr_req = 1'b0; if_r.sys_rd_req = 1'b0;

    vt[0] = '{init: 1'b0, wr: 1'b1, rd: 1'b0, exp_st: 4'd0, exp_busy: 1'b1, burst: 0};
    vt[1] = '{init: 1'b0, wr: 1'b0, rd: 1'b1, exp_st: 4'd0, exp_busy: 1'b1, burst: 0};
    vt[2] = '{init: 1'b1, wr: 1'b0, rd: 1'b0, exp_st: 4'd0, exp_busy: 1'b0, burst: 0};
    vt[3] = '{init: 1'b1, wr: 1'b1, rd: 1'b0, exp_st: 4'd1, exp_busy: 1'b1, burst: 1};
    vt[4] = '{init: 1'b1, wr: 1'b0, rd: 1'b1, exp_st: 4'd1, exp_busy: 1'b1, burst: 2};
    vt[5] = '{init: 1'b1, wr: 1'b1, rd: 1'b1, exp_st: 4'd1, exp_busy: 1'b1, burst: 3};

    for (int v = 0; v < 6; v++) begin
      reset_m($sformatf("vec%0d", v));
      rst_m = 1'b0;
      if_m.init_done  = vt[v].init;
      if_m.sys_wr_req = vt[v].wr;
      if_m.sys_rd_req = vt[v].rd;
      case (vt[v].burst)
        0: begin
          exp_t e;
          e = '{st: vt[v].exp_st, cnt: 1, wr_ack: 1'b0, rd_ack: 1'b0, busy: vt[v].exp_busy};
          exp_q.push_back(e);
        end
        1: push_wr();
        2: push_rd();
        default: begin push_wr(); push_rd(); end
      endcase
      run_q($sformatf("vec%0d", v));
    end

    // reset asserted in the middle of a read burst
    begin
      int k;
      reset_m("rstmid");
      rst_m = 1'b0;
      if_m.init_done = 1'b1; if_m.sys_rd_req = 1'b1;
      k = 0;
      while (!(if_m.work_state == 4'd5 && if_m.cnt_clk == 9'd3) && k < 40) begin
        @(negedge clk);
        if (if_m.sdram_rd_ack) if_m.sys_rd_req = 1'b0;
        k++;
      end
      chk("rstmid reached RD", 16'(k < 40), 16'd1);
      rst_m = 1'b1;
      @(negedge clk);
      chk("rstmid state", 16'(if_m.work_state), 16'd0);
      chk("rstmid cnt_clk", 16'(if_m.cnt_clk), 16'd0);
      chk("rstmid rd_ack", 16'(if_m.sdram_rd_ack), 16'd0);
    end

    // refresh pending and write request arrive together: refresh first
    sel_r = 1'b1;
    repeat (3) @(negedge clk);
    rst_r = 1'b0;
    repeat (20) @(negedge clk);
    chk("ref idle before", 16'(if_r.work_state), 16'd0);
    if_r.init_done = 1'b1; if_r.sys_wr_req = 1'b1;
    push_ref();
    push_wr();
    run_q("ref_wr");

    // three missed refresh periods while init_done is low
    sel_r = 1'b0;
    reset_m("backlog");
    rst_m = 1'b0;
    repeat (15010) @(negedge clk);
    if_m.init_done = 1'b1;
`ifdef SDRAM_REF_BACKLOG_EN
    push_ref(); push_ref(); push_ref();
`else
    push_ref();
`endif
    push(4'd0, 6, 1'b0, 1);
    run_q("backlog");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
